rtc_bus_ctrl: RTL



---
 rtl/rtc_bus_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for the RTC chip's multiplexed address/data bus.
// One request runs an address phase, a bus-released gap, then a data phase.
module rtc_bus_ctrl #(
    parameter int unsigned T_SU  = 2,
    parameter int unsigned T_PW  = 10,
    parameter int unsigned T_H   = 2,
    parameter int unsigned T_GAP = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] ad_in_i,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       a_d_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CW = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_GAP,
        S_D_SET, S_D_STB, S_D_HLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [7:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]    ad_out_q, ad_out_d;
    logic          ad_oe_q, ad_oe_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d, a_d_q, a_d_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [CW-1:0] dwell(state_t s);
        case (s)
            S_A_SET, S_D_SET: dwell = CW'(T_SU - 1);
            S_A_STB, S_D_STB: dwell = CW'(T_PW - 1);
            S_A_HLD, S_D_HLD: dwell = CW'(T_H - 1);
            S_GAP:            dwell = CW'(T_GAP - 1);
            default:          dwell = '0;
        endcase
    endfunction

    function automatic state_t succ(state_t s);
        case (s)
            S_A_SET: succ = S_A_STB;
            S_A_STB: succ = S_A_HLD;
            S_A_HLD: succ = S_GAP;
            S_GAP:   succ = S_D_SET;
            S_D_SET: succ = S_D_STB;
            S_D_STB: succ = S_D_HLD;
            S_D_HLD: succ = S_DONE;
            default: succ = S_IDLE;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        if (state_q == S_IDLE) begin
            if (start_i) begin
                state_d = S_A_SET;
                rw_d    = rw_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
            end
        end else if (cnt_q == '0) begin
            state_d = succ(state_q);
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
        if (state_d != state_q) cnt_d = dwell(state_d);

        // Sample the chip's data on the final strobe-low cycle, before rd_n rises.
        if (state_q == S_D_STB && cnt_q == '0 && rw_q) rdata_d = ad_in_i;

        // Outputs are registered, so decode from the state being entered.
        cs_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);

        case (state_d)
            S_A_SET, S_A_STB, S_A_HLD: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                wr_n_d   = (state_d != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                cs_n_d  = 1'b0;
                ad_oe_d = ~rw_d;
                if (!rw_d) ad_out_d = wdata_d;
                if (state_d == S_D_STB) begin
                    wr_n_d = rw_d;
                    rd_n_d = ~rw_d;
                end
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ad_out_o = ad_out_q;
    assign ad_oe_o  = ad_oe_q;
    assign cs_n_o   = cs_n_q;
    assign rd_n_o   = rd_n_q;
    assign wr_n_o   = wr_n_q;
    assign a_d_o    = a_d_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
